// File: rtl/fetch_pkg.sv
// Shared constants and the {pc, instr} entry type for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  localparam logic [ADDR_W-1:0]  PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits never reach the PC.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with a separate occupancy counter and a
// synchronous flush that empties the queue and rewinds both pointers.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Guard against underflow/overflow even if the caller misbehaves.
  assign pop_ok_s  = pop_i & ~flush_i & (level_q != {LVL_W{1'b0}});
  assign push_ok_s = push_i & ~flush_i & ((level_q < LVL_W'(DEPTH)) | pop_ok_s);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      level_d  = {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: every read is qualified by a non-zero level.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, reads instruction memory and queues
// {pc, instr} pairs for decode; a redirect flushes and restarts fetch.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [31:0]       imem_addr_o,
  input  logic [31:0]       imem_instr_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       pc_plus4_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [LVL_W-1:0]  level_s;
  logic              has_entry_s;
  logic              pop_s;
  logic              push_s;
  fetch_entry_t      wr_entry_s;
  fetch_entry_t      head_s;
  logic [ENTRY_W-1:0] head_raw_s;

  assign has_entry_s = (level_s != {LVL_W{1'b0}});
  assign valid_o     = has_entry_s & ~redirect_i;
  assign pop_s       = valid_o & ready_i;
  assign push_s      = ~redirect_i & ((level_s < LVL_W'(DEPTH)) | pop_s);

  assign wr_entry_s.pc    = fetch_pc_q;
  assign wr_entry_s.instr = imem_instr_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
    end else if (push_s) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wr_entry_s),
    .rdata_o (head_raw_s),
    .level_o (level_s)
  );

  // Head fields are gated by stored occupancy so an empty queue shows zeros.
  assign head_s      = fetch_entry_t'(head_raw_s);
  assign instr_o     = has_entry_s ? head_s.instr : NOP;
  assign pc_o        = has_entry_s ? head_s.pc : 32'h0000_0000;
  assign pc_plus4_o  = pc_o + PC_STEP;
  assign imem_addr_o = fetch_pc_q;
  assign level_o     = level_s;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: vector table, wrap/reset
// sequences and a randomised scoreboard run.
module tb_instr_fetch_queue;

  localparam logic [31:0] XOR_K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid, ready = 1'b0;
  logic [31:0] instr, pc, pc_plus4;
  logic [2:0]  level;

  logic [31:0] w_addr, w_instr, w_instr_o, w_pc, w_pc_plus4;
  logic        w_valid;
  logic [2:0]  w_level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem_addr ^ XOR_K;
  assign w_instr    = w_addr ^ XOR_K;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .valid_o(valid),
    .ready_i(ready), .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc_plus4), .level_o(level)
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk_i(clk), .rst_i(rst), .imem_addr_o(w_addr), .imem_instr_i(w_instr),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .valid_o(w_valid),
    .ready_i(1'b1), .instr_o(w_instr_o), .pc_o(w_pc), .pc_plus4_o(w_pc_plus4), .level_o(w_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, rdy, redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [2:0]  e_level;
    logic [31:0] e_pc, e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic rdr, input logic [31:0] rp,
                     input logic ev, input logic [2:0] el, input logic [31:0] ep, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rdy = rd; v.redir = rdr; v.rpc = rp;
    v.e_valid = ev; v.e_level = el; v.e_pc = ep; v.e_addr = ea;
    vecs.push_back(v);
  endtask

  // Head-side checks shared by the table and hand sequences.
  task automatic chk_head(input string tag, input logic ev, input logic [2:0] el,
                          input logic [31:0] ep, input logic [31:0] ea);
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, ev});
    chk({tag, ".level"}, {29'b0, level}, {29'b0, el});
    chk({tag, ".addr"}, imem_addr, ea);
    if (ev) begin
      chk({tag, ".pc"}, pc, ep);
      chk({tag, ".instr"}, instr, ep ^ XOR_K);
      chk({tag, ".pc4"}, pc_plus4, ep + 32'd4);
    end else if (el == 3'd0) begin
      chk({tag, ".pc0"}, pc, 32'h0);
      chk({tag, ".instr0"}, instr, 32'h0);
      chk({tag, ".pc4_0"}, pc_plus4, 32'd4);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;
  sb_t sb[$];

  initial begin
    // reset then stream with ready high
    add(1,1,0,0, 0,0,0,0);
    add(0,1,0,0, 0,0,0,0);
    add(0,1,0,0, 1,1,0,4);
    add(0,1,0,0, 1,1,4,8);
    add(0,1,0,0, 1,1,8,12);
    add(0,1,0,0, 1,1,12,16);
    // stall until full, then drain in order
    add(1,0,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    add(0,0,0,0, 1,1,0,4);
    add(0,0,0,0, 1,2,0,8);
    add(0,0,0,0, 1,3,0,12);
    for (int i = 0; i < 6; i++) add(0,0,0,0, 1,4,0,16);
    add(0,1,0,0, 1,4,0,16);
    add(0,1,0,0, 1,4,4,20);
    add(0,1,0,0, 1,4,8,24);
    add(0,1,0,0, 1,4,12,28);
    add(0,1,0,0, 1,4,16,32);
    // redirect from full, then back-to-back redirects
    add(0,1,1,32'h0000_0103, 0,4,0,36);
    add(0,1,0,0, 0,0,0,32'h100);
    add(0,1,0,0, 1,1,32'h100,32'h104);
    add(0,1,0,0, 1,1,32'h104,32'h108);
    add(0,1,1,32'h0000_0200, 0,1,0,32'h10C);
    add(0,1,1,32'h0000_0302, 0,0,0,32'h200);
    add(0,1,0,0, 0,0,0,32'h300);
    add(0,1,0,0, 1,1,32'h300,32'h304);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; ready = vecs[i].rdy;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #1;
      chk_head($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_level, vecs[i].e_pc, vecs[i].e_addr);
      @(negedge clk);
    end
    redirect = 1'b0;

    // address wrap on the second instance
    rst = 1'b1; #1;
    chk("wrap.rst_addr", w_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic [31:0] wexp [5];
      wexp[0] = 32'h0; wexp[1] = 32'hFFFF_FFF8; wexp[2] = 32'hFFFF_FFFC;
      wexp[3] = 32'h0; wexp[4] = 32'h4;
      for (int i = 0; i < 5; i++) begin
        #1;
        chk($sformatf("wrap%0d.valid", i), {31'b0, w_valid}, {31'b0, (i != 0)});
        if (i != 0) begin
          chk($sformatf("wrap%0d.pc", i), w_pc, wexp[i]);
          chk($sformatf("wrap%0d.instr", i), w_instr_o, wexp[i] ^ XOR_K);
          chk($sformatf("wrap%0d.pc4", i), w_pc_plus4, wexp[i] + 32'd4);
        end
        @(negedge clk);
      end
    end

    // asynchronous reset between edges
    ready = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    chk("async.pre_level", {29'b0, level}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_head("async", 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk_head("async.r0", 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk_head("async.r1", 1'b1, 3'd1, 32'h0, 32'h4);
    @(negedge clk);

    // random ready and sparse redirects against a scoreboard
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      logic [31:0] mpc;
      logic        mpop;
      sb_t         e;
      sb.delete();
      mpc = 32'h0;
      for (int c = 0; c < 400; c++) begin
        ready       = 1'($urandom_range(0, 1));
        redirect    = ($urandom_range(0, 15) == 0);
        redirect_pc = $urandom;
        #1;
        chk("rnd.valid", {31'b0, valid}, {31'b0, (sb.size() != 0) && !redirect});
        chk("rnd.level", {29'b0, level}, sb.size());
        chk("rnd.addr", imem_addr, mpc);
        mpop = (sb.size() != 0) && ready && !redirect;
        if (mpop) begin
          e = sb.pop_front();
          chk("rnd.pc", pc, e.pc);
          chk("rnd.instr", instr, e.instr);
        end
        if (redirect) begin
          sb.delete();
          mpc = {redirect_pc[31:2], 2'b00};
        end else if (sb.size() < 4) begin
          e.pc = mpc; e.instr = mpc ^ XOR_K;
          sb.push_back(e);
          mpc = mpc + 32'd4;
        end
        @(negedge clk);
      end
    end
    redirect = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
